// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parameterised VGA timing generator with pixel-rate divider and registered sync/status outputs.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SYNC_POL  = 0,
   parameter int CLK_DIV   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        h_sinc,
   output logic        v_sinc,
   output logic [10:0] countH,
   output logic [10:0] countV,
   output logic        video_on,
   output logic        pix_en,
   output logic        line_start,
   output logic        frame_start
);
   localparam logic [10:0] H_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
   localparam logic        ACT     = (SYNC_POL != 0);

   logic [3:0]  div;
   logic [10:0] h_nxt, v_nxt;

   assign pix_en = (div == DIV_MAX);

   // status flags are decoded from the next position so they land together with the counters
   always_comb begin
      h_nxt = (countH == H_LAST) ? 11'd0 : countH + 11'd1;
      v_nxt = (countH != H_LAST) ? countV : (countV == V_LAST) ? 11'd0 : countV + 11'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div         <= '0;
         countH      <= H_LAST;
         countV      <= V_LAST;
         h_sinc      <= ~ACT;
         v_sinc      <= ~ACT;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div <= pix_en ? 4'd0 : div + 4'd1;
         if (pix_en) begin
            countH      <= h_nxt;
            countV      <= v_nxt;
            h_sinc      <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? ACT : ~ACT;
            v_sinc      <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? ACT : ~ACT;
            video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            line_start  <= (h_nxt == 11'd0);
            frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
         end
      end
   end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels; H_TOTAL = sum of H_VISIBLE, H_FP, H_SYNC and H_BP (800).
REQ-005 Parameters V_VISIBLE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, in lines; V_TOTAL = their sum (525).
REQ-006 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-007 Parameter CLK_DIV, default 2, clk cycles per pixel, range 1..16.
REQ-008 clk  input  1  system clock, rising edge.
REQ-009 rst  input  1  asynchronous reset, active-high.
REQ-010 h_sinc  output  1  horizontal sync.
REQ-011 v_sinc  output  1  vertical sync.
REQ-012 countH  output  11  current pixel column, 0..H_TOTAL-1.
REQ-013 countV  output  11  current line, 0..V_TOTAL-1.
REQ-014 video_on  output  1  high when countH < H_VISIBLE and countV < V_VISIBLE.
REQ-015 pix_en  output  1  pixel strobe; high on the clk cycle whose rising edge advances the position.
REQ-016 line_start  output  1  high while countH == 0.
REQ-017 frame_start  output  1  high while countH == 0 and countV == 0.

Function
REQ-018 Divider div (4 bit) SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL equal (div == CLK_DIV-1); with CLK_DIV=1, pix_en SHALL be constant 1 out of reset.
REQ-019 On a rising edge with pix_en=1, countH SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and countV SHALL increment in the same edge.
REQ-020 countV SHALL wrap from V_TOTAL-1 to 0 when countH wraps; simultaneous wrap of both counters SHALL produce position (0,0).
REQ-021 Counters SHALL hold when pix_en=0.
REQ-022 h_sinc SHALL be at SYNC_POL level when H_VISIBLE+H_FP <= countH < H_VISIBLE+H_FP+H_SYNC (656..751 default); otherwise it SHALL be at the inverse level.
REQ-023 v_sinc SHALL be at SYNC_POL level when V_VISIBLE+V_FP <= countV < V_VISIBLE+V_FP+V_SYNC (490..491 default); otherwise it SHALL be at the inverse level.
REQ-024 h_sinc, v_sinc, video_on, line_start and frame_start SHALL be registered, updated on the same edge as the counters, and always consistent with the countH/countV values visible in that cycle (zero relative latency).
REQ-025 Each position SHALL be held for exactly CLK_DIV clk cycles; one line SHALL be H_TOTAL*CLK_DIV cycles and one frame H_TOTAL*V_TOTAL*CLK_DIV cycles.
REQ-026 No output SHALL glitch or take an out-of-range counter value under any parameter set satisfying REQ-007.

Reset
REQ-027 While rst=1: div=0, countH=H_TOTAL-1, countV=V_TOTAL-1, h_sinc and v_sinc at the inactive level, video_on=0, line_start=0, frame_start=0.
REQ-028 The first pix_en edge after rst release SHALL move the position to (0,0), with frame_start=1, line_start=1 and video_on=1.
REQ-029 Assertion of rst mid-frame SHALL immediately force the REQ-027 values, with no completion of the current line.

Verification
REQ-030 Default params, release rst -> pix_en high on the 2nd clk; after the 2nd rising edge: countH=0, countV=0, frame_start=1, video_on=1, h_sinc=1, v_sinc=1.
REQ-031 Run one line -> h_sinc=0 for exactly 192 clks starting at countH=656; video_on falls at countH=640; line_start pulses every 1600 clks.
REQ-032 Run 2 frames -> v_sinc=0 only on countV 490..491 (3200 clks); frame_start period is 840000 clks; countV never exceeds 524.
REQ-033 Position (799,524) followed by a pix_en edge -> position (0,0), frame_start=1; with pix_en=0 the position holds.
REQ-034 rst asserted asynchronously at countH=300, countV=200 -> outputs reach REQ-027 values before the next clk edge; release -> REQ-030 sequence repeats.
REQ-035 CLK_DIV=1, SYNC_POL=1 -> pix_en constant 1, h_sinc=1 for exactly 96 clks per 800-clk line.
